// File: rtl/mdio_mgmt_master_pkg.sv
// mdio_pkg: shared Clause-22 frame constants and the frame-sequencer state type.
`default_nettype none

package mdio_pkg;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  localparam int CMD_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE      = 3'd1,
    CMD      = 3'd2,
    TA       = 3'd3,
    DATA     = 3'd4,
    IDLE_BIT = 3'd5
  } mdio_state_e;

endpackage

`default_nettype wire

// File: rtl/mdio_mgmt_master_if.sv
// mdio_mgmt_master_if: request/response bus between the MAC config block and the MDIO master.
`default_nettype none

interface mdio_mgmt_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_phy_addr;
  logic [4:0]  req_reg_addr;
  logic [15:0] req_wdata;
  logic        req_pre_sup;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_phy_addr, req_reg_addr, req_wdata, req_pre_sup,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_phy_addr, req_reg_addr, req_wdata, req_pre_sup,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/mdio_mgmt_master_clk_gen.sv
// mdio_clk_gen: MDC divider with one-cycle strobes ahead of each MDC rise and fall.
`default_nettype none

module mdio_clk_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic sig_CLK,
  input  logic sig_RESET_N,
  input  logic en_i,
  output logic mdc_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mdc_q, mdc_d;
  logic             term;

  always_comb begin
    term  = (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    mdc_d = mdc_q;
    if (!en_i) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else if (term) begin
      cnt_d = '0;
      mdc_d = ~mdc_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sig_CLK) begin
    if (!sig_RESET_N) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

  assign mdc_o      = mdc_q;
  assign rise_stb_o = en_i && term && !mdc_q;
  assign fall_stb_o = en_i && term && mdc_q;

endmodule

`default_nettype wire

// File: rtl/mdio_mgmt_master.sv
// mdio_mgmt_master: Clause-22 MDIO master turning register requests into MDC/MDIO frames.
`default_nettype none

module mdio_mgmt_master #(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic                sig_CLK,
  input  logic                sig_RESET_N,
  mdio_mgmt_master_if.slave   mgmt,
  output logic                sig_MDCLK,
  output logic                sig_MDIO_O,
  output logic                sig_MDIO_OE,
  input  logic                sig_MDIO_I
);

  import mdio_pkg::*;

  localparam logic [6:0] PRE_LAST  = 7'(PREAMBLE_LEN - 1);
  localparam logic [6:0] CMD_LAST  = 7'(CMD_BITS - 1);
  localparam logic [6:0] TA_LAST   = 7'(TA_BITS - 1);
  localparam logic [6:0] DATA_LAST = 7'(DATA_BITS - 1);

  mdio_state_e state_q, state_d;
  logic [6:0]  bitcnt_q, bitcnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic [15:0] rx_q, rx_d;
  logic        write_q, write_d;
  logic        ta_err_q, ta_err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rise_stb, fall_stb;

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .sig_CLK    (sig_CLK),
    .sig_RESET_N(sig_RESET_N),
    .en_i       (state_q != IDLE),
    .mdc_o      (sig_MDCLK),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    rx_d        = rx_q;
    write_d     = write_q;
    ta_err_d    = ta_err_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    sig_MDIO_O  = 1'b1;
    sig_MDIO_OE = 1'b0;

    case (state_q)
      IDLE: begin
        if (mgmt.req_valid) begin
          write_d  = mgmt.req_write;
          shreg_d  = {MDIO_ST, mgmt.req_write ? MDIO_OP_WR : MDIO_OP_RD,
                      mgmt.req_phy_addr, mgmt.req_reg_addr,
                      mgmt.req_write ? MDIO_TA_WR : 2'b00,
                      mgmt.req_write ? mgmt.req_wdata : 16'h0000};
          bitcnt_d = '0;
          rx_d     = '0;
          ta_err_d = 1'b0;
          state_d  = (mgmt.req_pre_sup || PREAMBLE_LEN == 0) ? CMD : PRE;
        end
      end
      PRE: begin
        sig_MDIO_OE = 1'b1;
        if (fall_stb) begin
          bitcnt_d = (bitcnt_q == PRE_LAST) ? 7'd0 : bitcnt_q + 7'd1;
          if (bitcnt_q == PRE_LAST) state_d = CMD;
        end
      end
      CMD: begin
        sig_MDIO_OE = 1'b1;
        sig_MDIO_O  = shreg_q[31];
        if (fall_stb) begin
          shreg_d  = {shreg_q[30:0], 1'b0};
          bitcnt_d = (bitcnt_q == CMD_LAST) ? 7'd0 : bitcnt_q + 7'd1;
          if (bitcnt_q == CMD_LAST) state_d = TA;
        end
      end
      TA: begin
        sig_MDIO_OE = write_q;
        sig_MDIO_O  = write_q ? shreg_q[31] : 1'b1;
        // A PHY pulls the second turnaround bit low; a high level means nobody answered.
        if (rise_stb && !write_q && bitcnt_q == TA_LAST) ta_err_d = sig_MDIO_I;
        if (fall_stb) begin
          shreg_d  = {shreg_q[30:0], 1'b0};
          bitcnt_d = (bitcnt_q == TA_LAST) ? 7'd0 : bitcnt_q + 7'd1;
          if (bitcnt_q == TA_LAST) state_d = DATA;
        end
      end
      DATA: begin
        sig_MDIO_OE = write_q;
        sig_MDIO_O  = write_q ? shreg_q[31] : 1'b1;
        if (rise_stb && !write_q) rx_d = {rx_q[14:0], sig_MDIO_I};
        if (fall_stb) begin
          shreg_d  = {shreg_q[30:0], 1'b0};
          bitcnt_d = (bitcnt_q == DATA_LAST) ? 7'd0 : bitcnt_q + 7'd1;
          if (bitcnt_q == DATA_LAST) state_d = IDLE_BIT;
        end
      end
      IDLE_BIT: begin
        if (fall_stb) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? 16'h0000 : rx_q;
          rsp_err_d   = !write_q && ta_err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sig_CLK) begin
    if (!sig_RESET_N) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      rx_q        <= '0;
      write_q     <= 1'b0;
      ta_err_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      rx_q        <= rx_d;
      write_q     <= write_d;
      ta_err_q    <= ta_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign mgmt.req_ready = (state_q == IDLE) && sig_RESET_N;
  assign mgmt.busy      = (state_q != IDLE);
  assign mgmt.rsp_valid = rsp_valid_q;
  assign mgmt.rsp_rdata = rsp_rdata_q;
  assign mgmt.rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mdio_mgmt_master.sv
// tb_mdio_mgmt_master: directed and randomized frames against a bit-list model of Clause-22 framing.
`default_nettype none

module tb_mdio_mgmt_master;

  localparam int D       = 10;
  localparam int PRE_LEN = 32;
  localparam int BITP    = 2 * D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mdclk, mdo, mdoe;
  logic mdi = 1'b1;

  mdio_mgmt_master_if bus();

  mdio_mgmt_master #(.CLK_DIV(D), .PREAMBLE_LEN(PRE_LEN)) dut (
    .sig_CLK    (clk),
    .sig_RESET_N(rst_n),
    .mgmt       (bus),
    .sig_MDCLK  (mdclk),
    .sig_MDIO_O (mdo),
    .sig_MDIO_OE(mdoe),
    .sig_MDIO_I (mdi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int last_wait = 0;

  bit m_o[$];
  bit m_oe[$];
  bit m_in[$];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Appends w bits of v (MSB first) with the expected OE and the PHY-side level on MDIO_I.
  task automatic push_bits(input logic [15:0] v, input int w, input bit oe, input logic [15:0] in_v);
    for (int i = w - 1; i >= 0; i--) begin
      m_o.push_back(v[i]);
      m_oe.push_back(oe);
      m_in.push_back(in_v[i]);
    end
  endtask

  task automatic run_frame(input string name, input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                           input logic [15:0] wd, input bit pre_sup, input bit present,
                           input logic [15:0] phy_data, input bit hold_valid, input int abort_at);
    logic [127:0] cap_o, cap_oe, want_o, want_oe;
    logic [15:0]  exp_rdata;
    logic         exp_err;
    int n, len, k, off, mdc_bad, busy_bad, rdy_bad, rsp_bad;

    m_o.delete(); m_oe.delete(); m_in.delete();
    if (!pre_sup) for (int i = 0; i < PRE_LEN; i++) push_bits(16'h1, 1, 1'b1, 16'h1);
    push_bits(16'h1, 2, 1'b1, 16'hFFFF);
    push_bits(wr ? 16'h1 : 16'h2, 2, 1'b1, 16'hFFFF);
    push_bits({11'd0, phy}, 5, 1'b1, 16'hFFFF);
    push_bits({11'd0, rg}, 5, 1'b1, 16'hFFFF);
    if (wr) push_bits(16'h2, 2, 1'b1, 16'hFFFF);
    else    push_bits(16'h0, 2, 1'b0, present ? 16'h2 : 16'h3);
    if (wr) push_bits(wd, 16, 1'b1, 16'hFFFF);
    else    push_bits(16'h0, 16, 1'b0, present ? phy_data : 16'hFFFF);
    push_bits(16'h1, 1, 1'b0, 16'h1);
    exp_rdata = wr ? 16'h0000 : (present ? phy_data : 16'hFFFF);
    exp_err   = !wr && !present;

    n = m_o.size();
    len = n * BITP + 1;
    want_o = '0; want_oe = '0; cap_o = '0; cap_oe = '0;
    for (int i = 0; i < n; i++) begin
      want_o[i]  = m_o[i];
      want_oe[i] = m_oe[i];
    end

    last_wait = 0;
    while (bus.req_ready !== 1'b1 && last_wait < 200) begin
      tick();
      last_wait++;
    end
    check_val({name, " ready"}, bus.req_ready, 1'b1);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_phy_addr = phy;
    bus.req_reg_addr = rg;
    bus.req_wdata    = wd;
    bus.req_pre_sup  = pre_sup;

    mdc_bad = 0; busy_bad = 0; rdy_bad = 0; rsp_bad = 0;
    for (int c = 1; c <= len; c++) begin
      tick();
      if (c == 1 && !hold_valid) bus.req_valid = 1'b0;
      k   = (c - 1) / BITP;
      off = (c - 1) % BITP;
      if (c == abort_at) begin
        rst_n = 1'b0;
        tick();
        check_val({name, " abort mdc"}, mdclk, 1'b0);
        check_val({name, " abort oe"}, mdoe, 1'b0);
        check_val({name, " abort rsp"}, bus.rsp_valid, 1'b0);
        check_val({name, " abort ready"}, bus.req_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        mdi = 1'b1;
        tick();
        check_val({name, " post-rst ready"}, bus.req_ready, 1'b1);
        check_val({name, " post-rst rsp"}, {bus.rsp_valid, bus.busy, bus.rsp_rdata}, 18'h0);
        check_val({name, " pre-abort rsp"}, rsp_bad, 0);
        return;
      end
      if (c < len) begin
        if (mdclk !== (off >= D)) mdc_bad++;
        if (bus.busy !== 1'b1) busy_bad++;
        if (bus.req_ready !== 1'b0) rdy_bad++;
        if (bus.rsp_valid !== 1'b0) rsp_bad++;
        if (off == D / 2) begin
          cap_o[k]  = mdo;
          cap_oe[k] = mdoe;
        end
        mdi = (k < n) ? m_in[k] : 1'b1;
      end
    end
    mdi = 1'b1;
    check_val({name, " rsp_valid"}, bus.rsp_valid, 1'b1);
    check_val({name, " rdata"}, bus.rsp_rdata, exp_rdata);
    check_val({name, " err"}, bus.rsp_err, exp_err);
    check_val({name, " end ready/busy/oe"}, {bus.req_ready, bus.busy, mdoe, mdclk}, 4'b1000);
    check_val({name, " oe stream"}, cap_oe, want_oe);
    check_val({name, " mdio stream"}, cap_o & want_oe, want_o & want_oe);
    check_val({name, " in-frame violations"}, {mdc_bad[15:0], busy_bad[15:0], rdy_bad[15:0], rsp_bad[15:0]}, 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_phy_addr = '0;
    bus.req_reg_addr = '0; bus.req_wdata = '0; bus.req_pre_sup = 1'b0;
    repeat (3) tick();
    check_val("reset pins", {mdclk, mdoe, mdo}, 3'b001);
    check_val("reset rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 18'h0);
    check_val("reset busy/ready", {bus.busy, bus.req_ready}, 2'b00);
    rst_n = 1'b1;
    tick();
    check_val("post-reset ready", bus.req_ready, 1'b1);

    run_frame("wr1140", 1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 1'b1, 16'h0, 1'b0, 0);
    run_frame("rd0141", 1'b0, 5'h01, 5'h02, 16'h0, 1'b0, 1'b1, 16'h0141, 1'b0, 0);
    run_frame("rd_nophy", 1'b0, 5'h03, 5'h01, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 0);
    run_frame("rd_presup", 1'b0, 5'h01, 5'h03, 16'h0, 1'b1, 1'b1, 16'hA5C3, 1'b0, 0);

    run_frame("b2b_1", 1'b1, 5'h02, 5'h04, 16'hBEEF, 1'b0, 1'b1, 16'h0, 1'b1, 0);
    run_frame("b2b_2", 1'b1, 5'h02, 5'h05, 16'h1234, 1'b1, 1'b1, 16'h0, 1'b0, 0);
    check_val("b2b gap", last_wait, 0);
    begin
      int extra = 0;
      for (int i = 0; i < 3 * BITP; i++) begin
        tick();
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) extra++;
      end
      check_val("b2b no third frame", extra, 0);
    end

    run_frame("abort", 1'b1, 5'h07, 5'h09, 16'h5A5A, 1'b0, 1'b1, 16'h0, 1'b0, 50 * BITP + 6);
    run_frame("rd_after_abort", 1'b0, 5'h07, 5'h09, 16'h0, 1'b0, 1'b1, 16'h3C0F, 1'b0, 0);

    for (int r = 0; r < 4; r++) begin
      run_frame($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                16'($urandom), 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
